// File: rtl/hazard_scheduler.sv
`default_nettype none
// hazard_scheduler: stall/bubble generation from a two-entry (E, M) Tuse/Tnew scoreboard.
// Define HAZARD_MD_INTERLOCK_EN to add the mult/div busy interlock; without it md_busy is tied to 0.
module hazard_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] d_waddr,
  input  logic [1:0] d_tnew,
  input  logic       d_is_md,
  input  logic       d_md_start,
  input  logic       d_md_div,
  output logic       stall,
  output logic       clr_de,
  output logic       md_busy
);

  logic [4:0] e_waddr_q, e_waddr_d, m_waddr_q, m_waddr_d;
  logic [1:0] e_tnew_q, e_tnew_d, m_tnew_q, m_tnew_d;
  logic       data_stall, md_stall, bubble_e;

  function automatic logic hazard(input logic [4:0] src, input logic [1:0] tuse,
                                  input logic [4:0] waddr, input logic [1:0] tnew);
    return (src != 5'd0) && (waddr == src) && (tnew > tuse);
  endfunction

  assign data_stall = hazard(d_rs, d_tuse_rs, e_waddr_q, e_tnew_q)
                    | hazard(d_rs, d_tuse_rs, m_waddr_q, m_tnew_q)
                    | hazard(d_rt, d_tuse_rt, e_waddr_q, e_tnew_q)
                    | hazard(d_rt, d_tuse_rt, m_waddr_q, m_tnew_q);

  // Reset gating keeps the outputs defined before the first reset edge clears state.
  assign stall    = (data_stall | md_stall) & ~flush & ~reset;
  assign clr_de   = stall | flush | reset;
  assign bubble_e = stall | flush;

  always_comb begin
    e_waddr_d = bubble_e ? 5'd0 : d_waddr;
    e_tnew_d  = bubble_e ? 2'd0 : d_tnew;
    m_waddr_d = flush ? 5'd0 : e_waddr_q;
    m_tnew_d  = (flush || e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_waddr_q <= 5'd0;
      e_tnew_q  <= 2'd0;
      m_waddr_q <= 5'd0;
      m_tnew_q  <= 2'd0;
    end else begin
      e_waddr_q <= e_waddr_d;
      e_tnew_q  <= e_tnew_d;
      m_waddr_q <= m_waddr_d;
      m_tnew_q  <= m_tnew_d;
    end
  end

`ifdef HAZARD_MD_INTERLOCK_EN
  localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int MD_W   = $clog2(MD_MAX + 1);

  logic            e_md_start_q, e_md_start_d, e_md_div_q, e_md_div_d;
  logic [MD_W-1:0] md_count_q, md_count_d;

  // A start already in E loads the counter even under flush; flush only bubbles the stages.
  always_comb begin
    e_md_start_d = d_md_start & ~bubble_e;
    e_md_div_d   = d_md_div & ~bubble_e;
    md_count_d   = md_count_q;
    if (e_md_start_q)
      md_count_d = e_md_div_q ? MD_W'(DIV_CYCLES) : MD_W'(MULT_CYCLES);
    else if (md_count_q != '0)
      md_count_d = md_count_q - MD_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_md_start_q <= 1'b0;
      e_md_div_q   <= 1'b0;
      md_count_q   <= '0;
    end else begin
      e_md_start_q <= e_md_start_d;
      e_md_div_q   <= e_md_div_d;
      md_count_q   <= md_count_d;
    end
  end

  assign md_stall = d_is_md & ((md_count_q != '0) | e_md_start_q);
  assign md_busy  = (md_count_q != '0) & ~reset;
`else
  logic unused_md;
  assign unused_md = ^{d_is_md, d_md_start, d_md_div};
  assign md_stall  = 1'b0;
  assign md_busy   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scheduler.sv
`default_nettype none
// Directed self-checking bench for hazard_scheduler (both interlock build variants).
module tb_hazard_scheduler;

  logic       clk = 1'b0;
  logic       reset, flush;
  logic [4:0] d_rs, d_rt, d_waddr;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_is_md, d_md_start, d_md_div;
  logic       stall, clr_de, md_busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_waddr(d_waddr), .d_tnew(d_tnew),
    .d_is_md(d_is_md), .d_md_start(d_md_start), .d_md_div(d_md_div),
    .stall(stall), .clr_de(clr_de), .md_busy(md_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [4:0] rs, input logic [1:0] tu_rs,
                       input logic [4:0] rt, input logic [1:0] tu_rt,
                       input logic [4:0] wa, input logic [1:0] tn);
    d_rs = rs; d_tuse_rs = tu_rs; d_rt = rt; d_tuse_rt = tu_rt;
    d_waddr = wa; d_tnew = tn;
    d_is_md = 1'b0; d_md_start = 1'b0; d_md_div = 1'b0;
    #1;
  endtask

  task automatic set_nop();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0);
  endtask

  task automatic set_md(input logic is_md, input logic start, input logic dv);
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0);
    d_is_md = is_md; d_md_start = start; d_md_div = dv;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0;
    set_nop();
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", stall); end
    n_cmp++; if (clr_de !== 1'b1) begin n_err++; $display("FAIL rst_clr_de: got %b want 1", clr_de); end
    n_cmp++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL rst_md_busy: got %b want 0", md_busy); end
    tick(); tick();
    reset = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL post_rst_stall: got %b want 0", stall); end
    n_cmp++; if (clr_de !== 1'b0) begin n_err++; $display("FAIL post_rst_clr_de: got %b want 0", clr_de); end
    n_cmp++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL post_rst_md_busy: got %b want 0", md_busy); end
  endtask

  task automatic test_load_use();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd2);          // lw $8
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL lw_issue_stall: got %b want 0", stall); end
    tick();
    set_d(5'd8, 2'd1, 5'd9, 2'd1, 5'd10, 2'd1);         // add $10,$8,$9
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL lu_stall_c1: got %b want 1", stall); end
    n_cmp++; if (clr_de !== 1'b1) begin n_err++; $display("FAIL lu_clr_c1: got %b want 1", clr_de); end
    tick();
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL lu_stall_c2: got %b want 0", stall); end
    n_cmp++; if (clr_de !== 1'b0) begin n_err++; $display("FAIL lu_clr_c2: got %b want 0", clr_de); end
    tick();
    set_nop(); tick(); tick();
  endtask

  task automatic test_alu_branch();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd1);          // add $8
    tick();
    set_d(5'd8, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);          // beq $8,$0
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL br_rs_stall_c1: got %b want 1", stall); end
    tick();
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL br_rs_stall_c2: got %b want 0", stall); end
    tick(); set_nop(); tick(); tick();
    // Same hazard on the rt port
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd12, 2'd1);
    tick();
    set_d(5'd0, 2'd0, 5'd12, 2'd0, 5'd0, 2'd0);
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL br_rt_stall: got %b want 1", stall); end
    tick(); set_nop(); tick(); tick();
  endtask

  task automatic test_m_stage();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd7, 2'd2);          // lw $7
    tick();
    set_nop();                                            // independent
    tick();
    set_d(5'd7, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0);          // branch on $7, lw now in M with tnew 1
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL m_stage_stall: got %b want 1", stall); end
    tick(); set_nop(); tick(); tick();
    // Tuse=3 never hazards even against the largest tnew
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd7, 2'd2);
    tick();
    set_d(5'd7, 2'd3, 5'd7, 2'd3, 5'd0, 2'd0);
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL tuse3_stall: got %b want 0", stall); end
    tick(); set_nop(); tick(); tick();
  endtask

  task automatic test_zero_reg();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd2);          // write to $0, tnew 2
    tick();
    set_d(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL zero_reg_stall: got %b want 0", stall); end
    tick(); set_nop(); tick(); tick();
  endtask

  task automatic test_flush();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd2);          // lw $8
    tick();
    set_d(5'd8, 2'd1, 5'd0, 2'd3, 5'd10, 2'd2);
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL fl_pre_stall: got %b want 1", stall); end
    flush = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL fl_stall: got %b want 0", stall); end
    n_cmp++; if (clr_de !== 1'b1) begin n_err++; $display("FAIL fl_clr_de: got %b want 1", clr_de); end
    tick();
    flush = 1'b0;
    set_d(5'd8, 2'd0, 5'd10, 2'd0, 5'd0, 2'd0);         // would hit stale M($8) or E($10)
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL fl_next_stall: got %b want 0", stall); end
    n_cmp++; if (clr_de !== 1'b0) begin n_err++; $display("FAIL fl_next_clr_de: got %b want 0", clr_de); end
    tick(); set_nop(); tick(); tick();
  endtask

`ifdef HAZARD_MD_INTERLOCK_EN
  task automatic run_md(input logic dv, output int st_cyc, output int busy_cyc, output bit done);
    set_md(1'b1, 1'b1, dv);
    tick();
    set_md(1'b1, 1'b0, 1'b0);                             // mfhi
    st_cyc = 0; busy_cyc = 0; done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (!stall && !md_busy) begin done = 1'b1; break; end
      st_cyc += int'(stall);
      busy_cyc += int'(md_busy);
      tick();
    end
    tick(); set_nop(); tick();
  endtask

  task automatic test_md_mult();
    int s, b; bit ok;
    run_md(1'b0, s, b, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL mult_timeout: got %b want 1", ok); end
    n_cmp++; if (s != 6) begin n_err++; $display("FAIL mult_stall_cycles: got %0d want 6", s); end
    n_cmp++; if (b != 5) begin n_err++; $display("FAIL mult_busy_cycles: got %0d want 5", b); end
  endtask

  task automatic test_md_div();
    int s, b; bit ok;
    run_md(1'b1, s, b, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL div_timeout: got %b want 1", ok); end
    n_cmp++; if (s != 11) begin n_err++; $display("FAIL div_stall_cycles: got %0d want 11", s); end
    n_cmp++; if (b != 10) begin n_err++; $display("FAIL div_busy_cycles: got %0d want 10", b); end
  endtask

  task automatic test_md_flush_priority();
    int b;
    set_md(1'b1, 1'b1, 1'b1);                             // div
    tick();
    set_nop();
    flush = 1'b1;
    #1;
    tick();
    flush = 1'b0;
    #1;
    n_cmp++; if (md_busy !== 1'b1) begin n_err++; $display("FAIL md_flush_busy: got %b want 1", md_busy); end
    b = 0;
    for (int i = 0; i < 20 && md_busy; i++) begin b++; tick(); end
    n_cmp++; if (b != 10) begin n_err++; $display("FAIL md_flush_busy_cycles: got %0d want 10", b); end
    tick();
  endtask

  task automatic test_reset_during_md();
    set_md(1'b1, 1'b1, 1'b1);
    tick();
    set_nop(); tick(); tick();
    n_cmp++; if (md_busy !== 1'b1) begin n_err++; $display("FAIL rmd_busy_before: got %b want 1", md_busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_md(1'b1, 1'b0, 1'b0);
    n_cmp++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL rmd_busy_after: got %b want 0", md_busy); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rmd_stall_after: got %b want 0", stall); end
    tick();
    n_cmp++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL rmd_busy_later: got %b want 0", md_busy); end
    set_nop(); tick();
  endtask
`else
  task automatic test_md_disabled();
    set_md(1'b1, 1'b1, 1'b1);
    tick();
    set_md(1'b1, 1'b0, 1'b0);
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL nomd_stall: got %b want 0", stall); end
    n_cmp++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL nomd_busy_c1: got %b want 0", md_busy); end
    tick();
    n_cmp++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL nomd_busy_c2: got %b want 0", md_busy); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL nomd_stall_c2: got %b want 0", stall); end
    set_nop(); tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load_use();
    test_alu_branch();
    test_m_stage();
    test_zero_reg();
    test_flush();
`ifdef HAZARD_MD_INTERLOCK_EN
    test_md_mult();
    test_md_div();
    test_md_flush_priority();
    test_reset_during_md();
`else
    test_md_disabled();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_scheduler.md
HAZARD_SCHEDULER -- requirements
Module: hazard_scheduler

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: busy cycles after a mult/multu start.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: busy cycles after a div/divu start.
REQ-003 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port flush, input, 1: exception/eret flush of the D, E and M stages.
REQ-006 SHALL have port d_rs, input, 5: D-stage source register 1 (A1).
REQ-007 SHALL have port d_rt, input, 5: D-stage source register 2 (A2).
REQ-008 SHALL have port d_tuse_rs, input, 2: cycles until rs is needed; 3 = rs not read.
REQ-009 SHALL have port d_tuse_rt, input, 2: cycles until rt is needed; 3 = rt not read.
REQ-010 SHALL have port d_waddr, input, 5: D-stage destination register; 0 = no write.
REQ-011 SHALL have port d_tnew, input, 2: cycles, counted from E entry, until the D-stage result is available.
REQ-012 SHALL have port d_is_md, input, 1: D instruction uses HI/LO or the mult/div unit.
REQ-013 SHALL have port d_md_start, input, 1: D instruction starts mult/div.
REQ-014 SHALL have port d_md_div, input, 1: the start is a div (1) or a mult (0).
REQ-015 SHALL have port stall, output, 1: freeze PC and IF/ID.
REQ-016 SHALL have port clr_de, output, 1: load a bubble into the ID/EX register.
REQ-017 SHALL have port md_busy, output, 1: mult/div unit is busy.

Function
REQ-018 SHALL hold internal scoreboard entries E and M, each holding {waddr[4:0], tnew[1:0], md_start, md_div}.
REQ-019 SHALL, on each edge with stall=0 and flush=0, load E from the D inputs.
REQ-020 SHALL, on each edge with stall=1, load E with a bubble {0,0,0,0}.
REQ-021 SHALL, on every edge, load M with E.waddr and sat_dec(E.tnew), where sat_dec(0)=0 and sat_dec(n)=n-1.
REQ-022 SHALL compute a per-entry hazard for rs: d_rs!=0 AND entry.waddr==d_rs AND entry.tnew>d_tuse_rs. Tuse=3 therefore never hazards.
REQ-023 SHALL compute the rt hazard identically, using d_rt and d_tuse_rt.
REQ-024 SHALL compute data_stall as the OR of the rs and rt hazards against entries E and M.
REQ-025 SHALL compute md_stall = d_is_md AND (md_busy OR E.md_start).
REQ-026 SHALL make stall = (data_stall OR md_stall) AND NOT flush, combinational in the same cycle (0-cycle latency).
REQ-027 SHALL make clr_de = stall OR flush.
REQ-028 SHALL load the md counter with MULT_CYCLES or DIV_CYCLES (selected by E.md_div) when E.md_start=1, otherwise decrement it while it is nonzero.
REQ-029 SHALL make md_busy = (md_count != 0).
REQ-030 SHALL size md_count to ceil(log2(max(MULT_CYCLES,DIV_CYCLES)+1)) bits and SHALL NOT wrap below 0.
REQ-031 SHALL, on flush, clear the E and M entries to bubbles; an md_count already running SHALL continue unaffected.
REQ-032 SHALL give E.md_start priority over a simultaneous flush for the md counter, so a start already in E is never lost.
REQ-033 SHALL give flush priority over stall in all stage updates.

Reset
REQ-034 SHALL, on reset, clear E, M and md_count to 0 on the next rising edge; reset overrides flush and stall.
REQ-035 SHALL drive stall=0, clr_de=1 and md_busy=0 while reset=1; after reset releases, stall=0, clr_de=0 and md_busy=0 until the D inputs create a hazard.

Configuration
REQ-036 SHALL implement the mult/div interlock (REQ-025, REQ-028 to REQ-030, REQ-032) only when macro HAZARD_MD_INTERLOCK_EN is defined.
REQ-037 SHALL, without HAZARD_MD_INTERLOCK_EN, tie md_busy to 0, force md_stall to 0 and omit md_count; the data-hazard behaviour is unchanged.

Verification
REQ-038 SHALL cover: lw $8 (d_waddr=8, d_tnew=2) followed by add with d_rs=8, d_tuse_rs=1 -> stall=1 and clr_de=1 for 1 cycle, then 0.
REQ-039 SHALL cover: add $8 (d_tnew=1) followed by beq with d_rs=8, d_tuse_rs=0 -> stall=1 for 1 cycle.
REQ-040 SHALL cover: d_rs=0 with E.waddr=0 and tnew=2 -> stall=0.
REQ-041 SHALL cover: mult enters E, then mfhi in D -> stall held 1+5 cycles, with md_busy=1 for exactly 5 cycles; div variant -> md_busy=1 for exactly 10 cycles.
REQ-042 SHALL cover: flush asserted while a lw hazard is active -> stall=0, clr_de=1, E and M cleared, and the next D instruction proceeds without stall.
REQ-043 SHALL cover: reset asserted during a div busy period -> md_busy=0 after the next edge, and there is no stall afterwards.
